// File: rtl/ysyx_22041211_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: load-type codes,
// access masks, FSM state encoding, owner IDs and the load mask helper.
package ysyx_22041211_mem_arb_pkg;

  localparam int unsigned DATA_LEN = 32;

  // Load-type codes follow the RISC-V funct3 encoding
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [7:0] LOAD_MASK_8  = 8'h01;
  localparam logic [7:0] LOAD_MASK_16 = 8'h03;
  localparam logic [7:0] LOAD_MASK_32 = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

  function automatic logic [7:0] load_mask(input logic [2:0] load_type);
    case (load_type)
      LOAD_LB, LOAD_LBU: load_mask = LOAD_MASK_8;
      LOAD_LH, LOAD_LHU: load_mask = LOAD_MASK_16;
      default:           load_mask = LOAD_MASK_32;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041211_mem_arb_load_ext.sv
// Load data extension: sign/zero-extends the low byte/halfword of the raw
// memory word according to the load type; LW (and unknown codes) pass through.
// Ports: raw (memory word), load_type (LOAD_* code), ext (extended word).
module ysyx_22041211_load_ext
  import ysyx_22041211_mem_arb_pkg::*;
(
  input  logic [DATA_LEN-1:0] raw,
  input  logic [2:0]          load_type,
  output logic [DATA_LEN-1:0] ext
);

  always_comb begin
    ext = raw;
    case (load_type)
      LOAD_LB:  ext = {{(DATA_LEN-8){raw[7]}}, raw[7:0]};
      LOAD_LBU: ext = {{(DATA_LEN-8){1'b0}}, raw[7:0]};
      LOAD_LH:  ext = {{(DATA_LEN-16){raw[15]}}, raw[15:0]};
      LOAD_LHU: ext = {{(DATA_LEN-16){1'b0}}, raw[15:0]};
      default:  ext = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_mem_arb.sv
// Two-requester memory arbiter: IFU and LSU share one memory port, with one
// transaction outstanding at a time (IDLE -> REQ -> WAIT -> RESP).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifu_req_valid/ready, ifu_addr      fetch request handshake
//   ifu_resp_valid, ifu_rdata          fetch completion pulse / word
//   lsu_req_valid/ready, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
//   lsu_load_type                      load/store request
//   lsu_resp_valid, lsu_rdata          completion pulse / extended load data
//   mem_req_valid/ready, mem_wen, mem_addr, mem_wdata, mem_mask
//                                      memory request (fields latched)
//   mem_resp_valid, mem_rdata          memory response
// Configuration: define YSYX_22041211_ARB_RR_EN for round-robin arbitration;
// default is fixed LSU priority.
module ysyx_22041211_mem_arb
  import ysyx_22041211_mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [DATA_LEN-1:0] ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_LEN-1:0] ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [DATA_LEN-1:0] lsu_addr,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [7:0]          lsu_wmask,
  input  logic [2:0]          lsu_load_type,
  output logic                lsu_resp_valid,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [7:0]          mem_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  state_t              state;
  owner_t              owner;
  logic [2:0]          load_type_q;
  logic [DATA_LEN-1:0] ext_data;
  logic                lsu_first;
  logic                grant_lsu;
  logic                grant_ifu;
  logic                idle;

`ifdef YSYX_22041211_ARB_RR_EN
  owner_t              last_grant;
`endif

  ysyx_22041211_load_ext u_load_ext (
    .raw       (mem_rdata),
    .load_type (load_type_q),
    .ext       (ext_data)
  );

  // Grants are combinational so ready rises in the same cycle as valid;
  // gated by rst_n so both readies read 0 while reset is held.
  always_comb begin
`ifdef YSYX_22041211_ARB_RR_EN
    lsu_first = (last_grant == OWNER_IFU);
`else
    lsu_first = 1'b1;
`endif
    idle      = rst_n && (state == ST_IDLE);
    grant_lsu = idle && lsu_req_valid && (!ifu_req_valid || lsu_first);
    grant_ifu = idle && ifu_req_valid && !grant_lsu;
  end

  assign lsu_req_ready = grant_lsu;
  assign ifu_req_ready = grant_ifu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      owner          <= OWNER_IFU;
      load_type_q    <= LOAD_LW;
      mem_req_valid  <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_mask       <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
`ifdef YSYX_22041211_ARB_RR_EN
      last_grant     <= OWNER_IFU;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_lsu) begin
            owner         <= OWNER_LSU;
            mem_wen       <= lsu_wen;
            mem_addr      <= lsu_addr;
            mem_wdata     <= lsu_wdata;
            mem_mask      <= lsu_wen ? lsu_wmask : load_mask(lsu_load_type);
            load_type_q   <= lsu_load_type;
            mem_req_valid <= 1'b1;
            state         <= ST_REQ;
`ifdef YSYX_22041211_ARB_RR_EN
            last_grant    <= OWNER_LSU;
`endif
          end else if (grant_ifu) begin
            owner         <= OWNER_IFU;
            mem_wen       <= 1'b0;
            mem_addr      <= ifu_addr;
            mem_wdata     <= '0;
            mem_mask      <= LOAD_MASK_32;
            load_type_q   <= LOAD_LW;
            mem_req_valid <= 1'b1;
            state         <= ST_REQ;
`ifdef YSYX_22041211_ARB_RR_EN
            last_grant    <= OWNER_IFU;
`endif
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            if (owner == OWNER_LSU) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= mem_wen ? '0 : ext_data;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= mem_rdata;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          ifu_resp_valid <= 1'b0;
          lsu_resp_valid <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
